// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_pkg: shared widths, reset constants and encodings for the writeback scheduler.
package regfile_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_SP = 5'd2;
    localparam logic [XLEN-1:0] SP_INIT_DEF = 32'h7fffefe4;
    typedef enum logic {INIT, RUN} state_e;
    typedef enum logic {REQ_ALU, REQ_MEM} req_e;
endpackage

// File: rtl/regfile_wb_scheduler_arb.sv
// rr_arbiter2: two-way round-robin grant; a tie goes to the requester that did not win last.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic [1:0] req,
    input  req_e       lg,
    input  logic       advance,
    output logic [1:0] gnt
);
    always_comb gnt = !advance ? 2'b00 : &req ? (lg == REQ_MEM ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: sweeps x1..x31 to their reset values, then merges ALU and load
// writebacks onto the single register-file write port with one-cycle latency.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter logic [XLEN-1:0] SP_INIT = SP_INIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    output logic                  we3,
    output logic [REG_ADDR_W-1:0] a3,
    output logic [XLEN-1:0]       wd3,
    output logic                  init_done
);
    state_e                state_q, state_d;
    req_e                  lg_q, lg_d;
    logic [REG_ADDR_W-1:0] idx_q, idx_d, a3_q, a3_d, rd;
    logic [XLEN-1:0]       wd3_q, wd3_d, data;
    logic                  we3_q, we3_d;
    logic [1:0]            gnt;

    rr_arbiter2 u_arb (
        .req     ({mem_valid, alu_valid}),
        .lg      (lg_q),
        .advance (state_q == RUN),
        .gnt     (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign init_done = state_q == RUN;
    assign we3       = we3_q;
    assign a3        = a3_q;
    assign wd3       = wd3_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lg_d    = lg_q;
        rd      = gnt[1] ? mem_rd : alu_rd;
        data    = gnt[1] ? mem_data : alu_data;
        // writes to x0 are accepted but dropped at the port
        we3_d   = |gnt && rd != '0;
        a3_d    = we3_d ? rd : '0;
        wd3_d   = we3_d ? data : '0;
        if (state_q == INIT) begin
            we3_d   = 1'b1;
            a3_d    = idx_q;
            wd3_d   = idx_q == REG_SP ? SP_INIT : '0;
            idx_d   = idx_q + 1'b1;
            state_d = &idx_q ? RUN : INIT;
        end else if (|gnt) begin
            lg_d = gnt[0] ? REQ_ALU : REQ_MEM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= 5'd1;
            lg_q    <= REQ_MEM;
            we3_q   <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lg_q    <= lg_d;
            we3_q   <= we3_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
        end
    end
endmodule
